// File: rtl/inst_mem_loader.sv
// Debug program loader: packs UART bytes MSB-first into words and writes them to instruction memory.
// Write strobe one cycle after the 4th byte; rx_ready only in RECV, so bytes stall (never drop) elsewhere.
module inst_mem_loader #(
  parameter int               NBITS     = 32,
  parameter int               MEM_DEPTH = 64,
  parameter logic [NBITS-1:0] HALT_WORD = {NBITS{1'b1}},
  localparam int              CW        = $clog2(MEM_DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  output logic             o_rx_ready,
  output logic             o_inst_mem_wr_en,
  output logic [NBITS-1:0] o_inst_mem_addr,
  output logic [NBITS-1:0] o_inst_mem_data,
  output logic             o_cpu_rst,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_overflow,
  output logic [CW-1:0]    o_word_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       byte_idx_q;
  logic [NBITS-1:0] shift_q;
  logic [NBITS-1:0] data_q;
  logic [NBITS-1:0] addr_q;
  logic [CW-1:0]    word_count_q;
  logic             overflow_q;

  logic             byte_acc;
  logic             word_is_halt;
  logic             last_slot;
  logic [NBITS-1:0] packed_word;

  assign byte_acc     = i_rx_valid && (state_q == S_RECV);
  assign word_is_halt = (data_q == HALT_WORD);
  assign last_slot    = (word_count_q == CW'(MEM_DEPTH - 1));
  assign packed_word  = {shift_q[NBITS-9:0], i_rx_data};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (i_start) state_d = S_RECV;
      S_RECV:         if (byte_acc && (byte_idx_q == 2'd3)) state_d = S_WRITE;
      S_WRITE:        state_d = (word_is_halt || last_slot) ? S_DONE : S_RECV;
      default:        state_d = S_IDLE;
    endcase
  end

  // addr/data are latched with the 4th byte so they are stable for the whole WRITE cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      byte_idx_q   <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      addr_q       <= '0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            byte_idx_q   <= '0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
          end
        end
        S_RECV: begin
          if (i_rx_valid) begin
            shift_q    <= packed_word;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              data_q <= packed_word;
              addr_q <= {{(NBITS-CW-2){1'b0}}, word_count_q, 2'b00};
            end
          end
        end
        S_WRITE: begin
          word_count_q <= word_count_q + CW'(1);
          // a halt word landing in the last slot is a clean finish, not an overflow
          if (!word_is_halt && last_slot) overflow_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_rx_ready       = (state_q == S_RECV);
  assign o_inst_mem_wr_en = (state_q == S_WRITE);
  assign o_busy           = (state_q == S_RECV) || (state_q == S_WRITE);
  assign o_done           = (state_q == S_DONE);
  assign o_cpu_rst        = (state_q != S_DONE);
  assign o_inst_mem_addr  = addr_q;
  assign o_inst_mem_data  = data_q;
  assign o_overflow       = overflow_q;
  assign o_word_count     = word_count_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Two loaders (depth 64 and depth 4) share one byte stream; a transaction-level model tracks each.
module tb_inst_mem_loader;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;

  logic [1:0]  rdy, wen, cpu_rst, busy, done, ovf;
  logic [31:0] addr [2];
  logic [31:0] data [2];
  logic [6:0]  wcnt0;
  logic [2:0]  wcnt1;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  inst_mem_loader #(.NBITS(32), .MEM_DEPTH(64)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_rx_ready(rdy[0]), .o_inst_mem_wr_en(wen[0]), .o_inst_mem_addr(addr[0]),
    .o_inst_mem_data(data[0]), .o_cpu_rst(cpu_rst[0]), .o_busy(busy[0]), .o_done(done[0]),
    .o_overflow(ovf[0]), .o_word_count(wcnt0)
  );

  inst_mem_loader #(.NBITS(32), .MEM_DEPTH(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_rx_ready(rdy[1]), .o_inst_mem_wr_en(wen[1]), .o_inst_mem_addr(addr[1]),
    .o_inst_mem_data(data[1]), .o_cpu_rst(cpu_rst[1]), .o_busy(busy[1]), .o_done(done[1]),
    .o_overflow(ovf[1]), .o_word_count(wcnt1)
  );

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  localparam int P_IDLE = 0, P_LOAD = 1, P_WR = 2, P_DONE = 3;
  int          depth [2] = '{64, 4};
  int          ph    [2] = '{P_IDLE, P_IDLE};
  int          nb    [2] = '{0, 0};
  int          wc    [2] = '{0, 0};
  bit          movf  [2] = '{1'b0, 1'b0};
  logic [7:0]  got   [2][4];
  logic [31:0] ew_addr [2];
  logic [31:0] ew_data [2];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        ph[k] = P_IDLE; nb[k] = 0; wc[k] = 0; movf[k] = 1'b0;
      end else begin
        case (ph[k])
          P_IDLE, P_DONE: if (start) begin
            ph[k] = P_LOAD; nb[k] = 0; wc[k] = 0; movf[k] = 1'b0;
          end
          P_LOAD: if (rx_valid) begin
            got[k][nb[k]] = rx_data;
            nb[k]++;
            if (nb[k] == 4) begin
              nb[k] = 0;
              ew_addr[k] = 32'(wc[k] * 4);
              ew_data[k] = {got[k][0], got[k][1], got[k][2], got[k][3]};
              ph[k] = P_WR;
            end
          end
          P_WR: begin
            wc[k]++;
            if (ew_data[k] == HALT) ph[k] = P_DONE;
            else if (wc[k] == depth[k]) begin ph[k] = P_DONE; movf[k] = 1'b1; end
            else ph[k] = P_LOAD;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare + write capture ----------------
  logic [31:0] log_addr0 [$];
  logic [31:0] log_data0 [$];
  logic [31:0] log_addr1 [$];
  logic [31:0] log_data1 [$];

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        string p;
        p = (k == 0) ? "A." : "B.";
        check({p, "rx_ready"}, rdy[k], ph[k] == P_LOAD);
        check({p, "wr_en"}, wen[k], ph[k] == P_WR);
        check({p, "busy"}, busy[k], (ph[k] == P_LOAD) || (ph[k] == P_WR));
        check({p, "done"}, done[k], ph[k] == P_DONE);
        check({p, "cpu_rst"}, cpu_rst[k], ph[k] != P_DONE);
        check({p, "overflow"}, ovf[k], movf[k]);
        check({p, "word_count"}, (k == 0) ? longint'(wcnt0) : longint'(wcnt1), wc[k]);
        if (ph[k] == P_WR) begin
          check({p, "addr"}, addr[k], ew_addr[k]);
          check({p, "data"}, data[k], ew_data[k]);
        end
      end
      if (wen[0]) begin log_addr0.push_back(addr[0]); log_data0.push_back(data[0]); end
      if (wen[1]) begin log_addr1.push_back(addr[1]); log_data1.push_back(data[1]); end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // holds valid until loader A takes the byte; B sees the same stream
  task automatic send_byte(input logic [7:0] b);
    bit taken;
    taken = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 50 && !taken; i++) begin
      @(negedge clk);
      if (rdy[0]) taken = 1'b1;
    end
    if (!taken) check("send_byte_timeout", 0, 1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic clear_logs();
    log_addr0.delete(); log_data0.delete(); log_addr1.delete(); log_data1.delete();
  endtask

  initial begin
    logic [31:0] w;
    @(negedge clk);
    chk_en = 1'b1;
    // reset values
    check("rst.wr_en", wen[0], 0);
    check("rst.addr", addr[0], 0);
    check("rst.data", data[0], 0);
    check("rst.cpu_rst", cpu_rst[0], 1);
    check("rst.rx_ready", rdy[0], 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // program 20080005 + halt, with a 10-cycle stall after byte 2
    clear_logs();
    pulse_start();
    send_byte(8'h20);
    send_byte(8'h08);
    repeat (10) begin
      @(negedge clk);
      check("gap.rx_ready", rdy[0], 1);
      check("gap.wr_en", wen[0], 0);
    end
    tick();
    send_byte(8'h00);
    send_byte(8'h05);
    send_word(HALT);
    repeat (2) tick();
    @(negedge clk);
    check("t1.nwrites", log_addr0.size(), 2);
    if (log_addr0.size() == 2) begin
      check("t1.addr0", log_addr0[0], 0);
      check("t1.data0", log_data0[0], 32'h2008_0005);
      check("t1.addr1", log_addr0[1], 4);
      check("t1.data1", log_data0[1], 32'hFFFF_FFFF);
    end
    check("t1.done", done[0], 1);
    check("t1.cpu_rst", cpu_rst[0], 0);
    check("t1.word_count", wcnt0, 2);
    tick();

    // restart from DONE; stray start mid-word; B overflows after 4 words
    clear_logs();
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      w = {8'h10 + 8'(i), 8'hA0, 8'h00, 8'(i)};
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      if (i == 1) pulse_start();
      send_byte(w[15:8]);
      send_byte(w[7:0]);
    end
    repeat (2) tick();
    @(negedge clk);
    check("t3.A.addr_first", (log_addr0.size() > 0) ? log_addr0[0] : 32'hDEAD, 0);
    check("t3.A.word_count", wcnt0, 5);
    check("t3.B.nwrites", log_addr1.size(), 4);
    if (log_addr1.size() == 4) begin
      check("t3.B.last_addr", log_addr1[3], 12);
      check("t3.B.last_data", log_data1[3], 32'h13A0_0003);
    end
    check("t3.B.done", done[1], 1);
    check("t3.B.overflow", ovf[1], 1);
    check("t3.B.word_count", wcnt1, 4);
    tick();

    // reset two bytes into a word
    send_byte(8'h55);
    send_byte(8'h66);
    @(posedge clk);
    #3 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t5.wr_en", wen[0], 0);
      check("t5.cpu_rst", cpu_rst[0], 1);
      check("t5.addr", addr[0], 0);
      check("t5.data", data[0], 0);
      check("t5.word_count", wcnt0, 0);
      check("t5.busy", busy[0], 0);
    end
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // random programs with random valid gaps
    for (int n = 0; n < 40; n++) begin
      tick();
      if (!busy[0] || done[1]) pulse_start();
      w = ($urandom_range(0, 5) == 0) ? HALT : $urandom;
      for (int i = 3; i >= 0; i--) begin
        repeat ($urandom_range(0, 2)) tick();
        send_byte(w[i*8 +: 8]);
      end
    end
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
